// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter sharing one ALU between two requesters, with a
// latency tracker that serialises writebacks. Optional perf counters: ALU_ISSUE_ARB_PERF_EN.
module alu_issue_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TAG_W   = 4,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [6:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [6:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [6:0]       alu_op,
  output logic [WIDTH-1:0] alu_operand1,
  output logic [WIDTH-1:0] alu_operand2,
  input  logic [WIDTH-1:0] alu_result,
  output logic             wb_valid,
  output logic             wb_src,
  output logic [TAG_W-1:0] wb_tag,
  output logic [WIDTH-1:0] wb_data,
  output logic             busy,
  output logic [31:0]      perf_issue_cnt,
  output logic [31:0]      perf_stall_cnt
);

  localparam logic [6:0] OP_MUL  = 7'b0000010;
  localparam logic [6:0] OP_IDLE = 7'b0000000;

  function automatic logic f_is_mul(input logic [6:0] op);
    return (op == OP_MUL);
  endfunction

  logic             r_slot_v   [1:MUL_LAT];
  logic             r_slot_src [1:MUL_LAT];
  logic [TAG_W-1:0] r_slot_tag [1:MUL_LAT];
  logic [6:0]       r_alu_op;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic             r_rr_last;

  logic             w_slot1_next;
  logic             w_elig0;
  logic             w_elig1;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_iss_src;
  logic             w_iss_mul;
  logic [6:0]       w_iss_op;
  logic [WIDTH-1:0] w_iss_a;
  logic [WIDTH-1:0] w_iss_b;
  logic [TAG_W-1:0] w_iss_tag;
  logic             w_busy;

  // slot[2] becomes slot[1] at the next edge, so it is what a single op would collide with
  assign w_slot1_next = r_slot_v[2];
  assign w_elig0 = req0_valid & (f_is_mul(req0_op) | ~w_slot1_next);
  assign w_elig1 = req1_valid & (f_is_mul(req1_op) | ~w_slot1_next);

  // Round-robin grant among eligible requesters
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (w_elig0 && (!w_elig1 || r_rr_last)) begin
      w_grant0 = 1'b1;
    end else if (w_elig1) begin
      w_grant1 = 1'b1;
    end else begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
    end
  end

  // Select the granted request's fields
  always_comb begin
    w_iss_src = 1'b0;
    w_iss_op  = req0_op;
    w_iss_a   = req0_a;
    w_iss_b   = req0_b;
    w_iss_tag = req0_tag;
    if (w_grant1) begin
      w_iss_src = 1'b1;
      w_iss_op  = req1_op;
      w_iss_a   = req1_a;
      w_iss_b   = req1_b;
      w_iss_tag = req1_tag;
    end else begin
      w_iss_src = 1'b0;
    end
  end

  assign w_iss_mul  = f_is_mul(w_iss_op);
  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  // Tracker shift, issue registers and round-robin pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 1; k <= MUL_LAT; k++) begin
        r_slot_v[k]   <= 1'b0;
        r_slot_src[k] <= 1'b0;
        r_slot_tag[k] <= '0;
      end
      r_alu_op  <= OP_IDLE;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_rr_last <= 1'b1;
    end else begin
      for (int k = 1; k < MUL_LAT; k++) begin
        r_slot_v[k]   <= r_slot_v[k+1];
        r_slot_src[k] <= r_slot_src[k+1];
        r_slot_tag[k] <= r_slot_tag[k+1];
      end
      r_slot_v[MUL_LAT]   <= 1'b0;
      r_slot_src[MUL_LAT] <= 1'b0;
      r_slot_tag[MUL_LAT] <= '0;
      if (w_grant0 || w_grant1) begin
        r_alu_op  <= w_iss_op;
        r_alu_a   <= w_iss_a;
        r_alu_b   <= w_iss_b;
        r_rr_last <= w_iss_src;
        if (w_iss_mul) begin
          r_slot_v[MUL_LAT]   <= 1'b1;
          r_slot_src[MUL_LAT] <= w_iss_src;
          r_slot_tag[MUL_LAT] <= w_iss_tag;
        end else begin
          r_slot_v[1]   <= 1'b1;
          r_slot_src[1] <= w_iss_src;
          r_slot_tag[1] <= w_iss_tag;
        end
      end else begin
        r_alu_op <= OP_IDLE;
      end
    end
  end

  // Busy is any tracker slot occupied
  always_comb begin
    w_busy = 1'b0;
    for (int k = 1; k <= MUL_LAT; k++) begin
      w_busy = w_busy | r_slot_v[k];
    end
  end

  assign alu_op       = r_alu_op;
  assign alu_operand1 = r_alu_a;
  assign alu_operand2 = r_alu_b;
  assign wb_valid     = r_slot_v[1];
  assign wb_src       = r_slot_src[1];
  assign wb_tag       = r_slot_tag[1];
  assign wb_data      = r_slot_v[1] ? alu_result : '0;
  assign busy         = w_busy;

`ifdef ALU_ISSUE_ARB_PERF_EN
  logic [31:0] r_perf_issue;
  logic [31:0] r_perf_stall;
  logic        w_stall;

  assign w_stall = (req0_valid & ~w_grant0) | (req1_valid & ~w_grant1);

  // Issue and stall counters, free-running modulo 2^32
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_issue <= 32'd0;
      r_perf_stall <= 32'd0;
    end else begin
      if (w_grant0 || w_grant1) begin
        r_perf_issue <= r_perf_issue + 32'd1;
      end else begin
        r_perf_issue <= r_perf_issue;
      end
      if (w_stall) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end else begin
        r_perf_stall <= r_perf_stall;
      end
    end
  end

  assign perf_issue_cnt = r_perf_issue;
  assign perf_stall_cnt = r_perf_stall;
`else
  assign perf_issue_cnt = 32'd0;
  assign perf_stall_cnt = 32'd0;
`endif

endmodule
